// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-I subset core: opcodes, functs,
// ALU operation and FSM state enums.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, BRANCH, JUMP, MEM_RD, WB_MEM, MEM_WR, WB_ALU
  } state_t;

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU shared by every FSM step (PC increment, branch target,
// R/I-type execute, branch compare).
module mips_alu
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: result = XLEN'(a < b);
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = XLEN'($signed(b) >>> shamt);
      ALU_LUI:  result = {b[15:0], 16'h0000};
      default:  ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multi_cycle_mips_cpu.sv
// Multi-cycle MIPS-I subset CPU with one unified memory port; register file,
// datapath registers and the sequencing FSM live here, the ALU is shared.
module multi_cycle_mips_cpu
  import mips_pkg::*;
#(
  parameter int unsigned     MEM_WAIT = 3,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_read_data,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_read,
  output logic            mem_write
);

  localparam int unsigned     WAIT_W    = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [XLEN-1:0]   PC, pc_nxt, ir, ir_nxt, a_q, a_nxt, b_q, b_nxt;
  logic [XLEN-1:0]   alu_out, alu_out_nxt, mdr, mdr_nxt;
  logic [XLEN-1:0]   rf [32];
  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [XLEN-1:0]   rf_wd;
  logic [XLEN-1:0]   mem_addr_nxt, mem_write_data_nxt;
  logic              mem_read_nxt, mem_write_nxt;

  logic [5:0]      opcode, funct;
  logic [4:0]      rs, rt, rd, shamt;
  logic [15:0]     imm;
  logic [XLEN-1:0] imm_sext, imm_ext, rs_val, rt_val;
  alu_op_t         r_op, i_op, alu_op;
  logic            r_valid, i_zext;
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  logic            alu_zero;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign imm      = ir[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_ext  = i_zext ? {16'h0000, imm} : imm_sext;
  assign rs_val   = (rs == 5'd0) ? '0 : rf[rs];
  assign rt_val   = (rt == 5'd0) ? '0 : rf[rt];

  // Instruction field decode into ALU operations
  always_comb begin
    r_op    = ALU_ADD;
    r_valid = 1'b1;
    i_op    = ALU_ADD;
    i_zext  = 1'b0;
    case (funct)
      FN_ADD, FN_ADDU: r_op = ALU_ADD;
      FN_SUB, FN_SUBU: r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_XOR:  r_op = ALU_XOR;
      FN_NOR:  r_op = ALU_NOR;
      FN_SLT:  r_op = ALU_SLT;
      FN_SLTU: r_op = ALU_SLTU;
      FN_SLL:  r_op = ALU_SLL;
      FN_SRL:  r_op = ALU_SRL;
      FN_SRA:  r_op = ALU_SRA;
      default: r_valid = 1'b0;
    endcase
    case (opcode)
      OP_SLTI:  i_op = ALU_SLT;
      OP_SLTIU: i_op = ALU_SLTU;
      OP_ANDI:  begin i_op = ALU_AND; i_zext = 1'b1; end
      OP_ORI:   begin i_op = ALU_OR;  i_zext = 1'b1; end
      OP_XORI:  begin i_op = ALU_XOR; i_zext = 1'b1; end
      OP_LUI:   i_op = ALU_LUI;
      default:  i_op = ALU_ADD;
    endcase
  end

  mips_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .shamt  (shamt),
    .op     (alu_op),
    .result (alu_y),
    .zero   (alu_zero)
  );

  // Next-state, datapath and registered memory-port values
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    pc_nxt      = PC;
    ir_nxt      = ir;
    a_nxt       = a_q;
    b_nxt       = b_q;
    alu_out_nxt = alu_out;
    mdr_nxt     = mdr;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    alu_a       = PC;
    alu_b       = XLEN'(4);
    alu_op      = ALU_ADD;
    case (state)
      FETCH: begin
        if (mem_read) begin
          if (wait_cnt == WAIT_LAST) begin
            ir_nxt    = mem_read_data;
            pc_nxt    = alu_y;
            wait_nxt  = '0;
            state_nxt = DECODE;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      DECODE: begin
        a_nxt       = rs_val;
        b_nxt       = rt_val;
        alu_b       = {imm_sext[XLEN-3:0], 2'b00};
        alu_out_nxt = alu_y;
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_JR || funct == FN_JALR) state_nxt = JUMP;
            else if (r_valid)                       state_nxt = EXEC_R;
            else                                    state_nxt = FETCH;
          end
          OP_J, OP_JAL:    state_nxt = JUMP;
          OP_BEQ, OP_BNE:  state_nxt = BRANCH;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
          OP_LUI, OP_LW, OP_SW: state_nxt = EXEC_I;
          default:         state_nxt = FETCH;
        endcase
      end
      EXEC_R: begin
        alu_a       = a_q;
        alu_b       = b_q;
        alu_op      = r_op;
        alu_out_nxt = alu_y;
        state_nxt   = WB_ALU;
      end
      EXEC_I: begin
        alu_a       = a_q;
        alu_b       = imm_ext;
        alu_op      = i_op;
        alu_out_nxt = alu_y;
        if (opcode == OP_LW)      state_nxt = MEM_RD;
        else if (opcode == OP_SW) state_nxt = MEM_WR;
        else                      state_nxt = WB_ALU;
      end
      BRANCH: begin
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = ALU_SUB;
        if (alu_zero ^ (opcode == OP_BNE)) pc_nxt = alu_out;
        state_nxt = FETCH;
      end
      JUMP: begin
        if (opcode == OP_RTYPE) begin
          pc_nxt = a_q;
          rf_we  = (funct == FN_JALR);
          rf_wa  = rd;
          rf_wd  = PC;
        end else begin
          pc_nxt = {PC[31:28], ir[25:0], 2'b00};
          rf_we  = (opcode == OP_JAL);
          rf_wa  = 5'd31;
          rf_wd  = PC;
        end
        state_nxt = FETCH;
      end
      MEM_RD: begin
        if (mem_read) begin
          if (wait_cnt == WAIT_LAST) begin
            mdr_nxt   = mem_read_data;
            wait_nxt  = '0;
            state_nxt = WB_MEM;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      WB_MEM: begin
        rf_we     = 1'b1;
        rf_wa     = rt;
        rf_wd     = mdr;
        state_nxt = FETCH;
      end
      MEM_WR: state_nxt = FETCH;
      WB_ALU: begin
        rf_we     = 1'b1;
        rf_wa     = (opcode == OP_RTYPE) ? rd : rt;
        rf_wd     = alu_out;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    mem_read_nxt       = (state_nxt == FETCH) || (state_nxt == MEM_RD);
    mem_write_nxt      = (state_nxt == MEM_WR);
    mem_addr_nxt       = (state_nxt == MEM_RD || state_nxt == MEM_WR) ? alu_out_nxt : pc_nxt;
    mem_write_data_nxt = mem_write_nxt ? b_q : '0;
  end

  // Reset asserts abort any access immediately, including a pending store
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= FETCH;
      wait_cnt       <= '0;
      PC             <= RESET_PC;
      ir             <= '0;
      a_q            <= '0;
      b_q            <= '0;
      alu_out        <= '0;
      mdr            <= '0;
      mem_addr       <= RESET_PC;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state          <= state_nxt;
      wait_cnt       <= wait_nxt;
      PC             <= pc_nxt;
      ir             <= ir_nxt;
      a_q            <= a_nxt;
      b_q            <= b_nxt;
      alu_out        <= alu_out_nxt;
      mdr            <= mdr_nxt;
      mem_addr       <= mem_addr_nxt;
      mem_write_data <= mem_write_data_nxt;
      mem_read       <= mem_read_nxt;
      mem_write      <= mem_write_nxt;
      if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_multi_cycle_mips_cpu.sv
// Directed-program bench for multi_cycle_mips_cpu with a latency-modelled
// word memory that only returns valid data after MEM_WAIT stable cycles.
module tb_multi_cycle_mips_cpu;
  import mips_pkg::*;

  localparam int MEM_WAIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr, mem_read_data, mem_write_data;
  logic        mem_read, mem_write;

  logic [31:0] mem [1024];
  logic        tb_we;
  logic [9:0]  tb_idx;
  logic [31:0] tb_data;

  int wr_count = 0;
  int rd_age = 0, rd_run = 0, min_rd_run = 1000, wr_run = 0, max_wr_run = 0, overlap = 0;
  logic prev_read = 1'b0;
  logic [31:0] prev_addr = '0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  multi_cycle_mips_cpu #(.MEM_WAIT(MEM_WAIT), .RESET_PC(32'h0)) cpu (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_read_data  (mem_read_data),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write)
  );

  assign mem_read_data = (mem_read && rd_age >= MEM_WAIT) ? mem[mem_addr[11:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (tb_we) mem[tb_idx] <= tb_data;
    else if (mem_write) begin
      mem[mem_addr[11:2]] <= mem_write_data;
      wr_count <= wr_count + 1;
    end
  end

  // Read-latency model and port-protocol monitors
  always @(negedge clk) begin
    rd_age    <= (mem_read && prev_read && mem_addr == prev_addr) ? rd_age + 1 : 0;
    prev_read <= mem_read;
    prev_addr <= mem_addr;
    if (mem_read) rd_run <= rd_run + 1;
    else begin
      if (rd_run > 0 && rd_run < min_rd_run) min_rd_run <= rd_run;
      rd_run <= 0;
    end
    if (mem_write) wr_run <= wr_run + 1;
    else begin
      if (wr_run > max_wr_run) max_wr_run <= wr_run;
      wr_run <= 0;
    end
    if (mem_read && mem_write) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int i, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_idx = 10'(i); tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic wait_state(input state_t s, input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (cpu.state == s) ok = 1'b1;
      else @(negedge clk);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  function automatic logic [31:0] image(input int i);
    logic [31:0] w;
    case (i)
      0:  w = 32'h8C0100C8; // lw   r1,200(r0)
      1:  w = 32'h2002FFFD; // addi r2,r0,-3
      2:  w = 32'hAC0200CC; // sw   r2,204(r0)
      3:  w = 32'h20030005; // addi r3,r0,5
      4:  w = 32'h10230002; // beq  r1,r3,+2
      5:  w = 32'h20060001; // addi r6,r0,1 (skipped)
      6:  w = 32'h20060002; // addi r6,r0,2 (skipped)
      7:  w = 32'h14230001; // bne  r1,r3,+1 (falls through)
      8:  w = 32'h20070009; // addi r7,r0,9
      9:  w = 32'h0041202A; // slt  r4,r2,r1
      10: w = 32'h0041282B; // sltu r5,r2,r1
      11: w = 32'hAC0400D0; // sw   r4,208(r0)
      12: w = 32'hAC0500D4; // sw   r5,212(r0)
      13: w = 32'h0C000014; // jal  0x50
      14: w = 32'hAC0800D8; // sw   r8,216(r0)
      15: w = 32'hAC0600DC; // sw   r6,220(r0)
      16: w = 32'hAC0700E0; // sw   r7,224(r0)
      17: w = 32'hAC1F00E4; // sw   r31,228(r0)
      18: w = 32'h08000012; // j    0x48 (halt loop)
      20: w = 32'h3C081234; // lui  r8,0x1234
      21: w = 32'h35085678; // ori  r8,r8,0x5678
      22: w = 32'h00024843; // sra  r9,r2,1
      23: w = 32'h2C2AFFFF; // sltiu r10,r1,-1
      24: w = 32'h00225827; // nor  r11,r1,r2
      25: w = 32'hFC0A0000; // unknown opcode
      26: w = 32'h03E00008; // jr   r31
      50: w = 32'h00000005;
      60: w = 32'hAAAA5555;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  initial begin
    reset = 1'b0; tb_we = 1'b0; tb_idx = '0; tb_data = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", cpu.PC, 32'h0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_state", 32'(cpu.state), 32'(FETCH));
    for (int i = 0; i < 64; i++) poke(i, image(i));

    @(negedge clk);
    reset = 1'b1;
    wait_state(DECODE, "wait_dec0");
    check("pc_after_lw_fetch", cpu.PC, 32'h4);
    wait_state(FETCH, "wait_fetch1");
    wait_state(DECODE, "wait_dec1");
    check("pc_after_addi_fetch", cpu.PC, 32'h8);
    check("r1_lw", cpu.rf[1], 32'h5);
    wait_state(FETCH, "wait_fetch2");
    wait_state(DECODE, "wait_dec2");
    check("pc_after_sw_fetch", cpu.PC, 32'hC);

    for (int n = 0; n < 3000 && wr_count < 7; n++) @(negedge clk);
    check("store_count", 32'(wr_count), 32'd7);
    repeat (40) @(negedge clk);
    wait_state(FETCH, "wait_halt_fetch");
    check("halt_pc", cpu.PC, 32'h48);

    check("sw_addi_neg", mem[51], 32'hFFFF_FFFD);
    check("slt_signed", mem[52], 32'h1);
    check("sltu_unsigned", mem[53], 32'h0);
    check("lui_ori", mem[54], 32'h1234_5678);
    check("beq_skip", mem[55], 32'h0);
    check("bne_fallthru", mem[56], 32'h9);
    check("jal_ret_mem", mem[57], 32'h38);
    check("r31_jal", cpu.rf[31], 32'h38);
    check("sra", cpu.rf[9], 32'hFFFF_FFFE);
    check("sltiu_sext", cpu.rf[10], 32'h1);
    check("nor", cpu.rf[11], 32'h2);
    check("r0_zero", cpu.rf[0], 32'h0);
    check("rd_hold_min", 32'(min_rd_run >= MEM_WAIT + 1), 32'd1);
    check("wr_pulse_max", 32'(max_wr_run), 32'd1);
    check("rd_wr_overlap", 32'(overlap), 32'd0);

    // Restart on a single store, then pull reset while it is pending
    poke(0, 32'hAC0000F0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
        @(negedge clk);
        if (mem_write) seen = 1'b1;
      end
      check("sw_pending_seen", 32'(seen), 32'd1);
    end
    reset = 1'b0;
    #1;
    check("abort_mem_write", 32'(mem_write), 32'd0);
    check("abort_mem_read", 32'(mem_read), 32'd0);
    check("abort_pc", cpu.PC, 32'h0);
    check("abort_state", 32'(cpu.state), 32'(FETCH));
    repeat (3) @(negedge clk);
    check("abort_no_write", mem[60], 32'hAAAA_5555);
    check("abort_store_count", 32'(wr_count), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
